// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run/step/breakpoint sequencer.
// Latency: n/a (types, encodings and a pure helper function only).
// Backpressure: n/a.
package cpu_run_ctrl_pkg;

  // Default widths: word-addressed PC and the go-cycle counter / budget.
  localparam int PC_W_DEF  = 10;
  localparam int CNT_W_DEF = 32;

  // Sequencer states; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_STOP = 2'd3
  } run_state_t;

  // Reason for the most recent stop; visible on the stop_cause output.
  typedef enum logic [2:0] {
    C_NONE   = 3'd0,
    C_HALT   = 3'd1,
    C_BP     = 3'd2,
    C_BUDGET = 3'd3,
    C_PAUSE  = 3'd4,
    C_STEP   = 3'd5
  } stop_cause_t;

  // One-cycle button pulses, grouped so they can be arbitrated together.
  typedef struct packed {
    logic run;
    logic step;
    logic pause;
  } btn_pulse_t;

  // Same-cycle button pulses resolve as pause > step > run: a higher
  // priority pulse masks every lower one.
  function automatic btn_pulse_t arbitrate_buttons(input btn_pulse_t raw);
    btn_pulse_t res;
    res.pause = raw.pause;
    res.step  = raw.step & ~raw.pause;
    res.run   = raw.run  & ~raw.step & ~raw.pause;
    return res;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_edge_pulse.sv
// Registered rising-edge detector for one debounced button level.
// Latency: pulse is high for one cycle, starting one cycle after the level rise.
// Backpressure: none; every rise produces exactly one pulse.
module cpu_run_ctrl_edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_prev;

  // Remember last cycle's level and flag a 0->1 transition as a registered pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_prev <= 1'b0;
      pulse      <= 1'b0;
    end else begin
      level_prev <= level;
      pulse      <= level & ~level_prev;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer producing the single-cycle core's go enable; latches syscall-34 LED values.
// Latency: button level to go is 2 cycles (edge register + state register); go itself is combinational on state/pc.
// Backpressure: none; the core is simply not enabled while go is low.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             pause_btn,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [CNT_W-1:0] budget,
  input  logic [PC_W-1:0]  cpu_pc,
  input  logic             cpu_halt,
  input  logic             led_cpu_enable,
  input  logic [31:0]      led_data_in,
  output logic             go,
  output logic [1:0]       state,
  output logic [2:0]       stop_cause,
  output logic [CNT_W-1:0] run_cycles,
  output logic [31:0]      led_value,
  output logic             led_valid
);

  run_state_t  state_q, state_d;
  stop_cause_t cause_q, cause_d;
  btn_pulse_t  raw_pls, pls;

  logic             bp_skip_q;
  logic [CNT_W-1:0] cycles_q;
  logic [31:0]      led_value_q;
  logic             led_valid_q;

  logic bp_hit;
  logic budget_hit;
  logic halt_locked;
  logic run_entry;
  logic led_capture;

  // ---------------------------------------------------------------------
  // Button edge detection
  // ---------------------------------------------------------------------
  cpu_run_ctrl_edge_pulse u_run_edge (
    .clk   (clk),
    .rst   (rst),
    .level (run_btn),
    .pulse (raw_pls.run)
  );

  cpu_run_ctrl_edge_pulse u_step_edge (
    .clk   (clk),
    .rst   (rst),
    .level (step_btn),
    .pulse (raw_pls.step)
  );

  cpu_run_ctrl_edge_pulse u_pause_edge (
    .clk   (clk),
    .rst   (rst),
    .level (pause_btn),
    .pulse (raw_pls.pause)
  );

  assign pls = arbitrate_buttons(raw_pls);

  // ---------------------------------------------------------------------
  // Stop conditions
  // ---------------------------------------------------------------------
  // bp_skip lets a resumed run execute the instruction it stopped on once.
  assign bp_hit      = bp_en && (cpu_pc == bp_addr) && !bp_skip_q;
  // A zero budget means the run is unlimited.
  assign budget_hit  = (budget != '0) && (cycles_q == budget);
  // After a core halt the sequencer is parked until reset.
  assign halt_locked = (state_q == S_STOP) && (cause_q == C_HALT);
  assign run_entry   = (state_q != S_RUN) && (state_d == S_RUN);
  assign led_capture = go && led_cpu_enable;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // State and stop-cause registers; the cause holds until the next stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cause_q <= C_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and next-cause selection; RUN exits are checked in priority order.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE, S_STOP: begin
        if (!halt_locked) begin
          if (pls.run) begin
            state_d = S_RUN;
          end else if (pls.step) begin
            state_d = S_STEP;
          end
        end
      end
      S_RUN: begin
        if (cpu_halt) begin
          state_d = S_STOP;
          cause_d = C_HALT;
        end else if (bp_hit) begin
          state_d = S_STOP;
          cause_d = C_BP;
        end else if (budget_hit) begin
          state_d = S_STOP;
          cause_d = C_BUDGET;
        end else if (pls.pause) begin
          state_d = S_STOP;
          cause_d = C_PAUSE;
        end
      end
      S_STEP: begin
        // A step always lasts exactly one go cycle; breakpoints do not apply.
        state_d = S_STOP;
        cause_d = cpu_halt ? C_HALT : C_STEP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Core enable: always on in STEP, on in RUN unless a breakpoint or budget blocks the current instruction.
  always_comb begin
    go = 1'b0;
    case (state_q)
      S_STEP:  go = 1'b1;
      S_RUN:   go = !bp_hit && !budget_hit;
      default: go = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Breakpoint skip, cycle counter, LED latch
  // ---------------------------------------------------------------------
  // Arm the skip when resuming from a breakpoint stop; drop it once the core has advanced.
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_skip_q <= 1'b0;
    end else if (run_entry) begin
      bp_skip_q <= (cause_q == C_BP);
    end else if ((state_q == S_RUN) && go) begin
      bp_skip_q <= 1'b0;
    end
  end

  // Count go cycles since the last run entry, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_q <= '0;
    end else if (run_entry) begin
      cycles_q <= '0;
    end else if (go && (cycles_q != '1)) begin
      cycles_q <= cycles_q + CNT_W'(1);
    end
  end

  // Capture the LED value only on cycles the core actually executes.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_value_q <= '0;
      led_valid_q <= 1'b0;
    end else begin
      led_valid_q <= led_capture;
      if (led_capture) begin
        led_value_q <= led_data_in;
      end
    end
  end

  assign state      = state_q;
  assign stop_cause = cause_q;
  assign run_cycles = cycles_q;
  assign led_value  = led_value_q;
  assign led_valid  = led_valid_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed-vector bench for cpu_run_ctrl with a queue-based scoreboard.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares them.
// LED pulses are scoreboarded separately so any stray led_valid is caught.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_btn, step_btn, pause_btn, bp_en;
  logic [9:0]  bp_addr, cpu_pc;
  logic [31:0] budget;
  logic        cpu_halt, led_cpu_enable;
  logic [31:0] led_data_in;
  logic        go;
  logic [1:0]  state;
  logic [2:0]  stop_cause;
  logic [31:0] run_cycles;
  logic [31:0] led_value;
  logic        led_valid;

  always #5 clk = ~clk;

  cpu_run_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .run_btn        (run_btn),
    .step_btn       (step_btn),
    .pause_btn      (pause_btn),
    .bp_en          (bp_en),
    .bp_addr        (bp_addr),
    .budget         (budget),
    .cpu_pc         (cpu_pc),
    .cpu_halt       (cpu_halt),
    .led_cpu_enable (led_cpu_enable),
    .led_data_in    (led_data_in),
    .go             (go),
    .state          (state),
    .stop_cause     (stop_cause),
    .run_cycles     (run_cycles),
    .led_value      (led_value),
    .led_valid      (led_valid)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [1:0]  st;
    logic [2:0]  cause;
    logic        go;
    logic [31:0] rc;
    logic        lvld;
    logic [31:0] lv;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] led_q[$];
  exp_t        mon_e;
  logic [31:0] mon_lv;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic        finish_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int st, input int cs, input logic g,
                     input int rc, input logic lvld, input logic [31:0] lv);
    exp_t e;
    e.cyc   = cyc;
    e.name  = name;
    e.st    = 2'(st);
    e.cause = 3'(cs);
    e.go    = g;
    e.rc    = 32'(rc);
    e.lvld  = lvld;
    e.lv    = lv;
    exp_q.push_back(e);
  endtask

  // Monitor: compare queued expectations for this cycle, track LED pulses, and close the run.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (mon_e.cyc != cyc) begin
        $display("FAIL %s: compared late at cycle %0d, due at cycle %0d", mon_e.name, cyc, mon_e.cyc);
      end else if (state !== mon_e.st || stop_cause !== mon_e.cause || go !== mon_e.go ||
                   run_cycles !== mon_e.rc || led_valid !== mon_e.lvld || led_value !== mon_e.lv) begin
        $display("FAIL %s: got state=%0d cause=%0d go=%0b rc=%0d lvld=%0b lv=%h, want state=%0d cause=%0d go=%0b rc=%0d lvld=%0b lv=%h",
                 mon_e.name, state, stop_cause, go, run_cycles, led_valid, led_value,
                 mon_e.st, mon_e.cause, mon_e.go, mon_e.rc, mon_e.lvld, mon_e.lv);
      end else begin
        n_pass++;
      end
    end
    if (led_valid) begin
      n_checks++;
      if (led_q.size() == 0) begin
        $display("FAIL led_pulse: unexpected led_valid with led_value=%h, want no pulse", led_value);
      end else begin
        mon_lv = led_q.pop_front();
        if (led_value === mon_lv) n_pass++;
        else $display("FAIL led_pulse: led_value=%h, want %h", led_value, mon_lv);
      end
    end
    if (finish_req) begin
      while (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        n_checks++;
        $display("FAIL %s: never compared, due at cycle %0d", mon_e.name, mon_e.cyc);
      end
      while (led_q.size() > 0) begin
        mon_lv = led_q.pop_front();
        n_checks++;
        $display("FAIL led_pulse: expected pulse with %h never seen", mon_lv);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; run_btn = 1'b0; step_btn = 1'b0; pause_btn = 1'b0;
    bp_en = 1'b0; bp_addr = '0; budget = '0; cpu_pc = '0;
    cpu_halt = 1'b0; led_cpu_enable = 1'b0; led_data_in = '0;
    tick; tick;
    chk("reset", 0, 0, 0, 0, 0, 32'h0);
    rst = 1'b0;

    // Free run, then pause.
    run_btn = 1'b1; chk("run_pre", 0, 0, 0, 0, 0, 32'h0);
    tick; chk("run_pulse", 0, 0, 0, 0, 0, 32'h0);
    tick; chk("run_go0", 1, 0, 1, 0, 0, 32'h0);
    tick; chk("run_go1", 1, 0, 1, 1, 0, 32'h0);
    tick; chk("run_go2", 1, 0, 1, 2, 0, 32'h0);
    run_btn = 1'b0; pause_btn = 1'b1;
    tick; chk("pause_pulse", 1, 0, 1, 3, 0, 32'h0);
    tick; chk("pause_stop", 3, 4, 0, 4, 0, 32'h0);
    pause_btn = 1'b0;

    // Breakpoint at 0x010: hold, stop, resume executes it once, re-arms.
    bp_en = 1'b1; bp_addr = 10'h010; cpu_pc = 10'h00E; run_btn = 1'b1;
    tick; run_btn = 1'b0; chk("bp_pulse", 3, 4, 0, 4, 0, 32'h0);
    tick; chk("bp_run_0e", 1, 4, 1, 0, 0, 32'h0);
    tick; cpu_pc = 10'h00F; chk("bp_run_0f", 1, 4, 1, 1, 0, 32'h0);
    tick; cpu_pc = 10'h010; chk("bp_hold", 1, 4, 0, 2, 0, 32'h0);
    tick; chk("bp_stop", 3, 2, 0, 2, 0, 32'h0);
    run_btn = 1'b1;
    tick; run_btn = 1'b0; chk("bp_resume_pulse", 3, 2, 0, 2, 0, 32'h0);
    tick; chk("bp_skip_exec", 1, 2, 1, 0, 0, 32'h0);
    tick; cpu_pc = 10'h011; chk("bp_run_on", 1, 2, 1, 1, 0, 32'h0);
    tick; cpu_pc = 10'h010; chk("bp_rearm", 1, 2, 0, 2, 0, 32'h0);
    tick; chk("bp_stop2", 3, 2, 0, 2, 0, 32'h0);

    // Budget of 5 go cycles.
    bp_en = 1'b0; cpu_pc = 10'h020; budget = 32'd5; run_btn = 1'b1;
    tick; run_btn = 1'b0; chk("bud_pulse", 3, 2, 0, 2, 0, 32'h0);
    tick;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bud_go%0d", i), 1, 2, 1, i, 0, 32'h0);
      tick;
    end
    chk("bud_hold", 1, 2, 0, 5, 0, 32'h0);
    tick; chk("bud_stop", 3, 3, 0, 5, 0, 32'h0);
    budget = '0;

    // Single steps from IDLE; the counter accumulates across steps.
    rst = 1'b1;
    tick; chk("step_reset", 0, 0, 0, 0, 0, 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step_btn = 1'b1;
      tick; step_btn = 1'b0;
      chk($sformatf("step%0d_pre", k), (k == 1) ? 0 : 3, (k == 1) ? 0 : 5, 0, k - 1, 0, 32'h0);
      tick; chk($sformatf("step%0d_go", k), 2, (k == 1) ? 0 : 5, 1, k - 1, 0, 32'h0);
      tick; chk($sformatf("step%0d_stop", k), 3, 5, 0, k, 0, 32'h0);
    end

    // LED latch during a go cycle, then no update while go is low.
    step_btn = 1'b1;
    tick; step_btn = 1'b0; chk("led_step_pre", 3, 5, 0, 3, 0, 32'h0);
    tick; led_cpu_enable = 1'b1; led_data_in = 32'hDEADBEEF; led_q.push_back(32'hDEADBEEF);
    chk("led_go", 2, 5, 1, 3, 0, 32'h0);
    tick; led_cpu_enable = 1'b0; chk("led_latch", 3, 5, 0, 4, 1, 32'hDEADBEEF);
    tick; chk("led_one_shot", 3, 5, 0, 4, 0, 32'hDEADBEEF);
    led_cpu_enable = 1'b1; led_data_in = 32'h12345678;
    tick; chk("led_no_update", 3, 5, 0, 4, 0, 32'hDEADBEEF);
    led_cpu_enable = 1'b0;

    // Core halt locks the sequencer until reset.
    run_btn = 1'b1;
    tick; run_btn = 1'b0; chk("halt_pulse", 3, 5, 0, 4, 0, 32'hDEADBEEF);
    tick; cpu_halt = 1'b1; chk("halt_run", 1, 5, 1, 0, 0, 32'hDEADBEEF);
    tick; cpu_halt = 1'b0; chk("halt_stop", 3, 1, 0, 1, 0, 32'hDEADBEEF);
    run_btn = 1'b1;
    tick; run_btn = 1'b0;
    tick; chk("halt_run_ignored", 3, 1, 0, 1, 0, 32'hDEADBEEF);
    step_btn = 1'b1;
    tick; step_btn = 1'b0;
    tick; chk("halt_step_ignored", 3, 1, 0, 1, 0, 32'hDEADBEEF);
    rst = 1'b1;
    tick; rst = 1'b0; chk("halt_rst", 0, 0, 0, 0, 0, 32'h0);

    // Reset in the middle of a run: go drops, no LED capture.
    run_btn = 1'b1;
    tick; run_btn = 1'b0;
    tick; chk("midrun_go", 1, 0, 1, 0, 0, 32'h0);
    rst = 1'b1; led_cpu_enable = 1'b1; led_data_in = 32'hCAFEF00D;
    tick; rst = 1'b0; led_cpu_enable = 1'b0;
    chk("midrun_rst", 0, 0, 0, 0, 0, 32'h0);
    tick; chk("midrun_after", 0, 0, 0, 0, 0, 32'h0);

    tick; tick;
    finish_req = 1'b1;
  end

endmodule
